// File: rtl/cpu_rf_pkg.sv
// Shared definitions for the general register file: default geometry, the
// hard-wired zero register and a helper for slicing packed per-port vectors.
package cpu_rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

    // Widest packed port vector / field the slicing helper has to handle.
    localparam int VEC_MAX    = 128;
    localparam int FIELD_MAX  = 64;

    // Returns field idx (each w bits wide) of a packed port vector, zero-extended.
    function automatic logic [FIELD_MAX-1:0] slice_field(
        input logic [VEC_MAX-1:0] vec,
        input int                 idx,
        input int                 w
    );
        logic [VEC_MAX-1:0]   shifted;
        logic [FIELD_MAX-1:0] mask;
        shifted = vec >> (idx * w);
        mask    = (FIELD_MAX'(1) << w) - FIELD_MAX'(1);
        return FIELD_MAX'(shifted) & mask;
    endfunction

endpackage

// File: rtl/grf_mp_sb_if.sv
// Read, write and allocation bundle of the scoreboarded register file.
// master = issuing/writeback pipeline, slave = register file.
interface grf_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_ready;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     alloc_en;
    logic [ADDR_W-1:0]        alloc_addr;
    logic                     alloc_ok;
    logic [ADDR_W:0]          pending_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_ready, alloc_ok, pending_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_ready, alloc_ok, pending_cnt
    );
endinterface

// File: rtl/grf_scoreboard.sv
// Per-register pending bits: writes clear, accepted allocations set,
// allocation beats a same-cycle write. Also keeps a registered pending count.
module grf_scoreboard
    import cpu_rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_pending,
    output logic                     alloc_ok,
    output logic [ADDR_W:0]          pending_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;
    logic [ADDR_W:0]  cnt_nxt;
    logic             alloc_wr_hit;

    always_comb begin
        alloc_wr_hit = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] &&
                ADDR_W'(slice_field(VEC_MAX'(wr_addr), k, ADDR_W)) == alloc_addr)
                alloc_wr_hit = 1'b1;
        end
        alloc_ok = (alloc_addr == ADDR_W'(ZERO_REG)) || !pending[alloc_addr] || alloc_wr_hit;
    end

    always_comb begin
        rd_pending = '0;
        for (int i = 0; i < NUM_RD; i++)
            rd_pending[i] = pending[ADDR_W'(slice_field(VEC_MAX'(rd_addr), i, ADDR_W))];
    end

    // Clears first, then the allocation set, so a same-cycle alloc leaves the bit set.
    always_comb begin
        pending_nxt = pending;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k])
                pending_nxt[ADDR_W'(slice_field(VEC_MAX'(wr_addr), k, ADDR_W))] = 1'b0;
        end
        if (alloc_en && alloc_ok)
            pending_nxt[alloc_addr] = 1'b1;
        pending_nxt[ZERO_REG] = 1'b0;
        cnt_nxt = '0;
        for (int r = 0; r < DEPTH; r++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pending_nxt[r]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/grf_mp_sb.sv
// Multi-port general register file with optional write-through bypass and a
// per-register pending scoreboard for operand readiness and destination allocation.
module grf_mp_sb
    import cpu_rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    grf_mp_sb_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [NUM_RD-1:0] rd_pending;

    grf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .alloc_en    (bus.alloc_en),
        .alloc_addr  (bus.alloc_addr),
        .rd_addr     (bus.rd_addr),
        .rd_pending  (rd_pending),
        .alloc_ok    (bus.alloc_ok),
        .pending_cnt (bus.pending_cnt)
    );

    // NOTE: the array is reset as a whole because the register file must read
    // zero right after reset; this keeps it in flops rather than a RAM macro.
    // NOTE: ports are visited in ascending order with non-blocking updates, so
    // the last (highest-index) write to an address is the one that lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++)
                regs[r] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.wr_en[k] &&
                    ADDR_W'(slice_field(VEC_MAX'(bus.wr_addr), k, ADDR_W)) != ADDR_W'(ZERO_REG))
                    regs[ADDR_W'(slice_field(VEC_MAX'(bus.wr_addr), k, ADDR_W))] <=
                        DATA_W'(slice_field(VEC_MAX'(bus.wr_data), k, DATA_W));
            end
        end
    end

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              hit;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        bus.rd_data  = '0;
        bus.rd_ready = '0;
        ra           = '0;
        rd           = '0;
        hit          = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra  = ADDR_W'(slice_field(VEC_MAX'(bus.rd_addr), i, ADDR_W));
            rd  = regs[ra];
            hit = 1'b0;
            if (BYPASS) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (bus.wr_en[k] &&
                        ADDR_W'(slice_field(VEC_MAX'(bus.wr_addr), k, ADDR_W)) == ra) begin
                        rd  = DATA_W'(slice_field(VEC_MAX'(bus.wr_data), k, DATA_W));
                        hit = 1'b1;
                    end
                end
            end
            if (ra == ADDR_W'(ZERO_REG))
                rd = '0;
            bus.rd_data[i*DATA_W +: DATA_W] = rd;
            bus.rd_ready[i] = (ra == ADDR_W'(ZERO_REG)) || !rd_pending[i] || hit;
        end
    end

endmodule

// File: tb/tb_grf_mp_sb.sv
// Self-checking bench for grf_mp_sb: a behavioural register/pending model
// predicts every observation, predictions are queued when stimulus is driven.
module tb_grf_mp_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;

    typedef struct {
        string       tag;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic        aok;
        logic [5:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    grf_mp_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

    grf_mp_sb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .BYPASS (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    exp_t exp_q[$];

    logic [31:0] m_regs [32];
    logic        m_pend [32];

    logic [4:0]  t_rd_addr [2];
    logic [1:0]  t_wr_en;
    logic [4:0]  t_wr_addr [2];
    logic [31:0] t_wr_data [2];
    logic        t_alloc_en;
    logic [4:0]  t_alloc_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic wr_hit(input logic [4:0] a);
        for (int k = 0; k < 2; k++)
            if (t_wr_en[k] && t_wr_addr[k] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] r;
        if (a == 5'd0) return 32'h0;
        r = m_regs[a];
        for (int k = 0; k < 2; k++)
            if (t_wr_en[k] && t_wr_addr[k] == a) r = t_wr_data[k];
        return r;
    endfunction

    function automatic logic m_ready(input logic [4:0] a);
        return (a == 5'd0) || !m_pend[a] || wr_hit(a);
    endfunction

    function automatic logic m_aok();
        return (t_alloc_addr == 5'd0) || !m_pend[t_alloc_addr] || wr_hit(t_alloc_addr);
    endfunction

    function automatic logic [5:0] m_cnt();
        logic [5:0] c = '0;
        for (int r = 0; r < 32; r++) c = c + 6'(m_pend[r]);
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic aok;
        aok = m_aok();
        for (int k = 0; k < 2; k++)
            if (t_wr_en[k] && t_wr_addr[k] != 5'd0) begin
                m_regs[t_wr_addr[k]] = t_wr_data[k];
                m_pend[t_wr_addr[k]] = 1'b0;
            end
        if (t_alloc_en && aok && t_alloc_addr != 5'd0) m_pend[t_alloc_addr] = 1'b1;
    endtask

    // Drive the current stimulus and queue the model's prediction for it.
    task automatic drive(input string tag);
        exp_t e;
        bus.rd_addr    = {t_rd_addr[1], t_rd_addr[0]};
        bus.wr_en      = t_wr_en;
        bus.wr_addr    = {t_wr_addr[1], t_wr_addr[0]};
        bus.wr_data    = {t_wr_data[1], t_wr_data[0]};
        bus.alloc_en   = t_alloc_en;
        bus.alloc_addr = t_alloc_addr;
        e.tag = tag;
        e.d0  = m_read(t_rd_addr[0]);
        e.d1  = m_read(t_rd_addr[1]);
        e.rdy = {m_ready(t_rd_addr[1]), m_ready(t_rd_addr[0])};
        e.aok = m_aok();
        e.cnt = m_cnt();
        exp_q.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'(exp_q.size()), 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check({e.tag, ".d0"},  64'(bus.rd_data[31:0]),  64'(e.d0));
        check({e.tag, ".d1"},  64'(bus.rd_data[63:32]), 64'(e.d1));
        check({e.tag, ".rdy"}, 64'(bus.rd_ready),       64'(e.rdy));
        check({e.tag, ".aok"}, 64'(bus.alloc_ok),       64'(e.aok));
        check({e.tag, ".cnt"}, 64'(bus.pending_cnt),    64'(e.cnt));
    endtask

    task automatic idle();
        t_wr_en = '0; t_alloc_en = 1'b0; t_alloc_addr = '0;
        for (int k = 0; k < 2; k++) begin t_wr_addr[k] = '0; t_wr_data[k] = '0; end
    endtask

    // One cycle: drive at negedge, check 1 time unit later, then clock the model.
    task automatic step(input string tag);
        drive(tag);
        #1;
        compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        t_rd_addr[0] = a0; t_rd_addr[1] = a1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle(); rd(5'd0, 5'd1);
        model_reset();
        drive("reset_init");
        #1; compare();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Write reg 5 and allocate reg 7, then observe both.
        t_wr_en = 2'b01; t_wr_addr[0] = 5'd5; t_wr_data[0] = 32'h1234;
        t_alloc_en = 1'b1; t_alloc_addr = 5'd7; rd(5'd5, 5'd7);
        step("wr5_alloc7");
        idle(); step("see5_7");
        check("cnt_after_alloc7", 64'(bus.pending_cnt), 64'd1);

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        check("mid_reset.d0",  64'(bus.rd_data[31:0]), 64'h0);
        check("mid_reset.rdy", 64'(bus.rd_ready),      64'h3);
        check("mid_reset.cnt", 64'(bus.pending_cnt),   64'h0);
        model_reset();
        @(negedge clk); reset = 1'b0; @(negedge clk);

        // Bypass: same-cycle write is visible before the edge.
        t_wr_en = 2'b01; t_wr_addr[0] = 5'd3; t_wr_data[0] = 32'hDEAD_BEEF; rd(5'd3, 5'd0);
        drive("bypass"); #1;
        check("bypass_const", 64'(bus.rd_data[31:0]), 64'hDEAD_BEEF);
        compare();
        @(posedge clk); model_edge(); @(negedge clk);
        idle(); step("bypass_array");

        // Write-port conflict: port 1 wins.
        t_wr_en = 2'b11; t_wr_addr[0] = 5'd9; t_wr_data[0] = 32'h11;
        t_wr_addr[1] = 5'd9; t_wr_data[1] = 32'h22; rd(5'd9, 5'd3);
        step("conflict");
        idle(); drive("conflict_after"); #1;
        check("conflict_const", 64'(bus.rd_data[31:0]), 64'h22);
        compare(); @(posedge clk); model_edge(); @(negedge clk);

        // Zero register ignores writes and allocations.
        t_wr_en = 2'b11; t_wr_addr[0] = 5'd0; t_wr_data[0] = 32'hFFFF_FFFF;
        t_wr_addr[1] = 5'd0; t_wr_data[1] = 32'hFFFF_FFFF;
        t_alloc_en = 1'b1; t_alloc_addr = 5'd0; rd(5'd0, 5'd0);
        step("zero_wr");
        idle(); step("zero_after");

        // Scoreboard stall on reg 4.
        t_alloc_en = 1'b1; t_alloc_addr = 5'd4; rd(5'd4, 5'd0);
        step("alloc4");
        step("alloc4_again");
        check("cnt_stalled", 64'(bus.pending_cnt), 64'd1);
        idle(); t_wr_en = 2'b10; t_wr_addr[1] = 5'd4; t_wr_data[1] = 32'h55;
        step("write4");
        idle(); step("after_write4");
        check("cnt_cleared", 64'(bus.pending_cnt), 64'd0);

        // Simultaneous write and allocation of an already pending reg 12.
        t_alloc_en = 1'b1; t_alloc_addr = 5'd12; rd(5'd12, 5'd4);
        step("alloc12");
        t_wr_en = 2'b01; t_wr_addr[0] = 5'd12; t_wr_data[0] = 32'hCAFE_0012;
        drive("wr_alloc12"); #1;
        check("wr_alloc12_aok", 64'(bus.alloc_ok), 64'd1);
        compare(); @(posedge clk); model_edge(); @(negedge clk);
        idle(); step("after12");
        check("reg12_pending", 64'(bus.rd_ready[0]), 64'd0);

        // Random traffic over a small address range to build up contention.
        for (int n = 0; n < 60; n++) begin
            t_wr_en = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                t_wr_addr[k] = 5'($urandom_range(0, 15));
                t_wr_data[k] = $urandom;
                t_rd_addr[k] = 5'($urandom_range(0, 15));
            end
            t_alloc_en   = 1'($urandom_range(0, 1));
            t_alloc_addr = 5'($urandom_range(0, 15));
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
